// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: operation codes and FSM state.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ADD    = 4'd0;
  localparam logic [OP_W-1:0] SUB    = 4'd1;
  localparam logic [OP_W-1:0] NOT    = 4'd2;
  localparam logic [OP_W-1:0] AND    = 4'd3;
  localparam logic [OP_W-1:0] OR     = 4'd4;
  localparam logic [OP_W-1:0] XOR    = 4'd5;
  localparam logic [OP_W-1:0] SRA    = 4'd6;
  localparam logic [OP_W-1:0] SRL    = 4'd7;
  localparam logic [OP_W-1:0] SLA    = 4'd8;
  localparam logic [OP_W-1:0] SLL    = 4'd9;
  localparam logic [OP_W-1:0] OP_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Codes above OP_MAX have no ALU function behind them.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_MAX;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; pointer moves past the requester that completed.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_idx,
  output logic       gnt_idx_c,
  output logic       gnt_any_c
);

  logic ptr_q;
  logic ptr_d;

  // Pointer update: after a completion the other requester is favoured.
  always_comb begin
    ptr_d = ptr_q;
    if (done) begin
      ptr_d = ~done_idx;
    end
  end

  // Winner selection: the pointer only matters when both request.
  always_comb begin
    gnt_any_c = |req;
    gnt_idx_c = 1'b0;
    case (req)
      2'b01:   gnt_idx_c = 1'b0;
      2'b10:   gnt_idx_c = 1'b1;
      2'b11:   gnt_idx_c = ptr_q;
      default: gnt_idx_c = 1'b0;
    endcase
  end

  // Pointer register, reset favours requester 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, one operation at a time.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [N-1:0]    req0_a,
  input  logic [N-1:0]    req0_b,
  input  logic [OP_W-1:0] req1_op,
  input  logic [N-1:0]    req1_a,
  input  logic [N-1:0]    req1_b,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [OP_W-1:0] alu_sel,
  input  logic [N-1:0]    alu_result,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [N-1:0]    rsp_data,
  output logic            rsp_zero,
  output logic            rsp_neg,
  output logic            rsp_err
);

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic [N-1:0]    alu_a_q, alu_a_d;
  logic [N-1:0]    alu_b_q, alu_b_d;
  logic [OP_W-1:0] alu_sel_q, alu_sel_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [N-1:0]    rsp_data_q, rsp_data_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_neg_q, rsp_neg_d;
  logic            rsp_err_q, rsp_err_d;
  logic            done_c;
  logic            gnt_idx_c;
  logic            gnt_any_c;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .done      (done_c),
    .done_idx  (gnt_q),
    .gnt_idx_c (gnt_idx_c),
    .gnt_any_c (gnt_any_c)
  );

  // Next-state and datapath: accept in IDLE, capture in EXEC, hold until consumed in RESP.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_neg_d   = rsp_neg_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 2'b00;
    done_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_any_c) begin
          req_ready[gnt_idx_c] = 1'b1;
          gnt_d     = gnt_idx_c;
          alu_sel_d = gnt_idx_c ? req1_op : req0_op;
          alu_a_d   = gnt_idx_c ? req1_a  : req0_a;
          alu_b_d   = gnt_idx_c ? req1_b  : req0_b;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Illegal codes get a fixed error response; the ALU output is not used.
        if (op_illegal(alu_sel_q)) begin
          rsp_data_d = '0;
          rsp_zero_d = 1'b1;
          rsp_neg_d  = 1'b0;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = alu_result;
          rsp_zero_d = (alu_result == '0);
          rsp_neg_d  = alu_result[N-1];
          rsp_err_d  = 1'b0;
        end
        rsp_valid_d        = 2'b00;
        rsp_valid_d[gnt_q] = 1'b1;
        state_d            = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[gnt_q]) begin
          rsp_valid_d = 2'b00;
          done_c      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_neg_q   <= rsp_neg_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req0_op, req1_op;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [N-1:0] alu_a, alu_b;
  logic [3:0]   alu_sel;
  logic [N-1:0] alu_result;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_zero, rsp_neg, rsp_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_neg    (rsp_neg),
    .rsp_err    (rsp_err)
  );

  // The lab ALU: shifts are by one place; unknown codes output junk on purpose.
  function automatic logic [N-1:0] alu_f(input logic [3:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    case (op)
      4'd0:    return N'(a + b);
      4'd1:    return N'(a - b);
      4'd2:    return ~a;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return N'($signed(a) >>> 1);
      4'd7:    return a >> 1;
      4'd8:    return N'(a << 1);
      4'd9:    return N'(a << 1);
      default: return N'(9);
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_sel, alu_a, alu_b);

  function automatic logic [1:0] oh(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int who, input logic [3:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b);
    if (who == 0) begin
      req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu_a"},     32'(alu_a),     32'd0);
    chk({tag, "_alu_b"},     32'(alu_b),     32'd0);
    chk({tag, "_alu_sel"},   32'(alu_sel),   32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, "_flags"},     32'({rsp_zero, rsp_neg, rsp_err}), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    int         who;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_data;
    logic       exp_zero;
    logic       exp_neg;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  // One lone-requester transaction from IDLE through response handshake.
  task automatic single_txn(input vec_t v, input string tag);
    tick();
    set_req(v.who, v.op, v.a, v.b);
    req_valid = oh(v.who);
    @(negedge clk);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(oh(v.who)));
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk({tag, "_alu_sel"},      32'(alu_sel),   32'(v.op));
    chk({tag, "_alu_a"},        32'(alu_a),     32'(v.a));
    chk({tag, "_alu_b"},        32'(alu_b),     32'(v.b));
    chk({tag, "_exec_rvalid"},  32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh(v.who)));
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'(v.exp_data));
    chk({tag, "_rsp_flags"}, 32'({rsp_zero, rsp_neg, rsp_err}),
        32'({v.exp_zero, v.exp_neg, v.exp_err}));
    rsp_ready = oh(v.who);
    tick();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int n_acc;
    int n_rsp;
    int m_ptr;
    int m_stage;
    int m_g;
    int win;
    logic [3:0] m_data;
    logic       m_z, m_n, m_e;
    logic [1:0] acc;
    logic [1:0] exp_ready;
    logic [3:0] w_op, w_a, w_b;

    vecs[0] = '{0, 4'd0,  4'h3, 4'h4, 4'h7, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1, 4'd1,  4'h2, 4'h5, 4'hD, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{0, 4'd2,  4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1, 4'd12, 4'h1, 4'h2, 4'h0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{0, 4'd3,  4'hC, 4'hA, 4'h8, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1, 4'd6,  4'h8, 4'h0, 4'hC, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{0, 4'd9,  4'h9, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{0, 4'd15, 4'h7, 4'h7, 4'h0, 1'b1, 1'b0, 1'b1};

    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    do_reset();
    @(negedge clk);
    chk_all_zero("reset");

    // Table of lone-requester transactions.
    for (int i = 0; i < 8; i++) begin
      single_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Both requesting continuously: alternating grants, rsp_ready held high.
    do_reset();
    set_req(0, 4'd1, 4'h5, 4'h5);
    set_req(1, 4'd5, 4'hA, 4'h5);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    n_acc = 0;
    n_rsp = 0;
    for (int cyc = 0; cyc < 40 && n_rsp < 6; cyc++) begin
      if (cyc != 0) tick();
      if (n_acc == 6) req_valid = 2'b00;
      @(negedge clk);
      if (req_ready != 2'b00) begin
        chk($sformatf("cont_grant%0d", n_acc), 32'(req_ready), 32'(oh(n_acc % 2)));
        n_acc++;
      end
      if (rsp_valid != 2'b00) begin
        chk($sformatf("cont_rvalid%0d", n_rsp), 32'(rsp_valid), 32'(oh(n_rsp % 2)));
        chk($sformatf("cont_data%0d", n_rsp), 32'(rsp_data),
            (n_rsp % 2 == 0) ? 32'h0 : 32'hF);
        chk($sformatf("cont_flags%0d", n_rsp), 32'({rsp_zero, rsp_neg, rsp_err}),
            (n_rsp % 2 == 0) ? 32'b100 : 32'b010);
        n_rsp++;
      end
    end
    chk("cont_rsp_count", 32'(n_rsp), 32'd6);
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();

    // Backpressure: response held 5 cycles while both keep requesting.
    set_req(0, 4'd0, 4'h1, 4'h2);
    req_valid = 2'b01;
    @(negedge clk);
    chk("bp_accept", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    tick();
    set_req(1, 4'd3, 4'hF, 4'h6);
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_rvalid%0d", k), 32'(rsp_valid), 32'b01);
      chk($sformatf("bp_data%0d", k),   32'(rsp_data),  32'h3);
      chk($sformatf("bp_ready%0d", k),  32'(req_ready), 32'b00);
      if (k == 4) rsp_ready = 2'b01;
      tick();
    end
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_ptr_flip", 32'(req_ready), 32'b10);
    tick();
    req_valid = 2'b01;
    tick();
    @(negedge clk);
    chk("bp_r1_rvalid", 32'(rsp_valid), 32'b10);
    chk("bp_r1_data",   32'(rsp_data),  32'h6);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_r0_again", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("bp_r0_rvalid", 32'(rsp_valid), 32'b01);
    chk("bp_r0_data",   32'(rsp_data),  32'h3);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;

    // Reset during EXEC abandons the transaction.
    tick();
    set_req(0, 4'd0, 4'h3, 4'h4);
    req_valid = 2'b01;
    @(negedge clk);
    chk("rst_exec_accept", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_exec");
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("rst_no_rsp%0d", k), 32'(rsp_valid), 32'd0);
    end
    single_txn(vecs[1], "rst_r1_after");

    // Random traffic against a transaction-level model.
    do_reset();
    m_ptr = 0; m_stage = 0; m_g = 0;
    m_data = '0; m_z = 1'b0; m_n = 1'b0; m_e = 1'b0;
    acc = 2'b00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
          req_valid[i] = 1'b1;
        end
      end
      acc = 2'b00;
      @(negedge clk);
      exp_ready = 2'b00;
      win = 0;
      if (m_stage == 0 && req_valid != 2'b00) begin
        win = (req_valid == 2'b11) ? m_ptr : (req_valid[1] ? 1 : 0);
        exp_ready = oh(win);
      end
      chk("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
      chk("rnd_rsp_valid", 32'(rsp_valid), (m_stage == 2) ? 32'(oh(m_g)) : 32'd0);
      if (m_stage == 2) begin
        chk("rnd_rsp_data",  32'(rsp_data), 32'(m_data));
        chk("rnd_rsp_flags", 32'({rsp_zero, rsp_neg, rsp_err}), 32'({m_z, m_n, m_e}));
      end
      rsp_ready = 2'($urandom_range(0, 3));
      if (m_stage == 0) begin
        if (req_valid != 2'b00) begin
          m_g  = win;
          w_op = (win == 1) ? req1_op : req0_op;
          w_a  = (win == 1) ? req1_a  : req0_a;
          w_b  = (win == 1) ? req1_b  : req0_b;
          m_e    = (w_op > 4'd9);
          m_data = m_e ? 4'h0 : alu_f(w_op, w_a, w_b);
          m_z    = (m_data == 4'h0);
          m_n    = m_data[3];
          acc    = exp_ready;
          m_stage = 1;
        end
      end else if (m_stage == 1) begin
        m_stage = 2;
      end else if (rsp_ready[m_g]) begin
        m_stage = 0;
        m_ptr   = 1 - m_g;
      end
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (4) tick();
    rsp_ready = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
